// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_pkg
//  Brief    : Shared FSM/phase encodings, color codes and coordinate types
//             for the sprite renderer.
//  Revision : 1.0 - initial release
// ============================================================================
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RECT = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        ERASE = 1'b0,
        DRAW  = 1'b1
    } phase_t;

    localparam int BACKGROUND_COLOR = 0;
    localparam int PLAYER_COLOR     = 1;
    localparam int LASER_COLOR      = 2;
    localparam int ENEMY_COLOR      = 3;

    // Sized for the default 10-bit x / 9-bit y screen plus sign and headroom.
    typedef logic signed [11:0] coord_x_t;
    typedef logic signed [10:0] coord_y_t;

endpackage
`default_nettype wire

// File: rtl/rect_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : rect_scanner
//  Brief    : Rasterises one screen-clipped WxH rectangle around a center
//             point as a valid/ready pixel stream; pulses last at the end.
//  Revision : 1.0 - initial release
// ============================================================================
module rect_scanner
    import sprite_pkg::*;
#(
    parameter int SPRITE_WIDTH  = 32,
    parameter int SPRITE_HEIGHT = 32,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int X_W           = 10,
    parameter int Y_W           = 9,
    parameter int COLOR_W       = 4
)(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               go,
    input  logic [X_W-1:0]     center_x,
    input  logic [Y_W-1:0]     center_y,
    input  logic [COLOR_W-1:0] color,
    input  logic               pix_ready,
    output logic               pix_valid,
    output logic [X_W-1:0]     out_x,
    output logic [Y_W-1:0]     out_y,
    output logic [COLOR_W-1:0] out_color,
    output logic               last
);

    localparam int c_cxw = $clog2(SPRITE_WIDTH);
    localparam int c_cyw = $clog2(SPRITE_HEIGHT);
    localparam logic [c_cxw-1:0]      c_col_last = c_cxw'(SPRITE_WIDTH - 1);
    localparam logic [c_cyw-1:0]      c_row_last = c_cyw'(SPRITE_HEIGHT - 1);
    localparam logic signed [X_W+1:0] c_half_w   = (X_W+2)'(SPRITE_WIDTH / 2);
    localparam logic signed [Y_W+1:0] c_half_h   = (Y_W+2)'(SPRITE_HEIGHT / 2);
    localparam logic signed [X_W+1:0] c_scr_w    = (X_W+2)'(SCREEN_WIDTH);
    localparam logic signed [Y_W+1:0] c_scr_h    = (Y_W+2)'(SCREEN_HEIGHT);

    logic signed [X_W+1:0] r_px;
    logic signed [X_W+1:0] r_x0;
    logic signed [Y_W+1:0] r_py;
    logic [c_cxw-1:0]      r_col;
    logic [c_cyw-1:0]      r_row;
    logic                  r_active;
    logic [COLOR_W-1:0]    r_color;

    logic signed [X_W+1:0] w_x0;
    logic signed [Y_W+1:0] w_y0;
    logic                  w_on;
    logic                  w_adv;
    logic                  w_end;

    assign w_x0 = $signed({2'b00, center_x}) - c_half_w;
    assign w_y0 = $signed({2'b00, center_y}) - c_half_h;

    // Off-screen pixels still take their cycle but are never presented.
    assign w_on  = r_active && !r_px[X_W+1] && (r_px < c_scr_w)
                            && !r_py[Y_W+1] && (r_py < c_scr_h);
    assign w_adv = r_active && (!w_on || pix_ready);
    assign w_end = (r_col == c_col_last) && (r_row == c_row_last);

    assign last      = w_adv && w_end;
    assign pix_valid = w_on;
    assign out_x     = r_px[X_W-1:0];
    assign out_y     = r_py[Y_W-1:0];
    assign out_color = r_color;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_px     <= '0;
            r_x0     <= '0;
            r_py     <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_active <= 1'b0;
            r_color  <= '0;
        end else if (go) begin
            r_active <= 1'b1;
            r_px     <= w_x0;
            r_x0     <= w_x0;
            r_py     <= w_y0;
            r_col    <= '0;
            r_row    <= '0;
            r_color  <= color;
        end else if (w_adv) begin
            if (w_end) begin
                r_active <= 1'b0;
            end else if (r_col == c_col_last) begin
                r_col <= '0;
                r_px  <= r_x0;
                r_row <= r_row + c_cyw'(1);
                r_py  <= r_py + (Y_W+2)'(1);
            end else begin
                r_col <= r_col + c_cxw'(1);
                r_px  <= r_px + (X_W+2)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sprite_drawer.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_drawer
//  Brief    : Per-frame erase/redraw of N rectangle sprites as a clipped
//             (x, y, color) pixel stream with framebuffer back-pressure.
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_drawer
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES   = 4,
    parameter int SPRITE_WIDTH  = 32,
    parameter int SPRITE_HEIGHT = 32,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int X_W           = 10,
    parameter int Y_W           = 9,
    parameter int COLOR_W       = 4
)(
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic [NUM_SPRITES*X_W-1:0]     sprite_x,
    input  logic [NUM_SPRITES*Y_W-1:0]     sprite_y,
    input  logic [NUM_SPRITES-1:0]         sprite_en,
    input  logic [NUM_SPRITES*COLOR_W-1:0] sprite_color,
    output logic                           pix_valid,
    input  logic                           pix_ready,
    output logic [X_W-1:0]                 out_x,
    output logic [Y_W-1:0]                 out_y,
    output logic [COLOR_W-1:0]             out_color,
    output logic                           busy,
    output logic                           done
);

    localparam int c_iw = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [c_iw-1:0] c_idx_last = c_iw'(NUM_SPRITES - 1);

    state_t                         r_state;
    phase_t                         r_phase;
    logic [c_iw-1:0]                r_idx;
    logic                           r_erased;
    logic                           r_final;
    logic                           r_busy;
    logic                           r_done;

    logic [NUM_SPRITES*X_W-1:0]     r_lat_x;
    logic [NUM_SPRITES*Y_W-1:0]     r_lat_y;
    logic [NUM_SPRITES-1:0]         r_lat_en;
    logic [NUM_SPRITES*COLOR_W-1:0] r_lat_color;
    logic [NUM_SPRITES*X_W-1:0]     r_prev_x;
    logic [NUM_SPRITES*Y_W-1:0]     r_prev_y;
    logic [NUM_SPRITES-1:0]         r_prev_en;

    logic [NUM_SPRITES-1:0]         w_moved;
    logic                           w_go;
    logic [X_W-1:0]                 w_cx;
    logic [Y_W-1:0]                 w_cy;
    logic [COLOR_W-1:0]             w_color;
    logic                           w_last;

    generate
        for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_moved
            assign w_moved[i] = (r_prev_en[i] != r_lat_en[i]) ||
                                (r_prev_en[i] && r_lat_en[i] &&
                                 ((r_prev_x[i*X_W +: X_W] != r_lat_x[i*X_W +: X_W]) ||
                                  (r_prev_y[i*Y_W +: Y_W] != r_lat_y[i*Y_W +: Y_W])));
        end
    endgenerate

    // Once anything is erased, every enabled sprite is redrawn to repair overlaps.
    always_comb begin
        w_go    = 1'b0;
        w_cx    = r_lat_x[r_idx*X_W +: X_W];
        w_cy    = r_lat_y[r_idx*Y_W +: Y_W];
        w_color = r_lat_color[r_idx*COLOR_W +: COLOR_W];
        if (r_state == SCAN && !r_final) begin
            if (r_phase == ERASE) begin
                if (w_moved[r_idx] && r_prev_en[r_idx]) begin
                    w_go    = 1'b1;
                    w_cx    = r_prev_x[r_idx*X_W +: X_W];
                    w_cy    = r_prev_y[r_idx*Y_W +: Y_W];
                    w_color = COLOR_W'(BACKGROUND_COLOR);
                end
            end else if (r_lat_en[r_idx] && (r_erased || w_moved[r_idx])) begin
                w_go = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_phase     <= ERASE;
            r_idx       <= '0;
            r_erased    <= 1'b0;
            r_final     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_lat_x     <= '0;
            r_lat_y     <= '0;
            r_lat_en    <= '0;
            r_lat_color <= '0;
            r_prev_x    <= '0;
            r_prev_y    <= '0;
            r_prev_en   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_lat_x     <= sprite_x;
                        r_lat_y     <= sprite_y;
                        r_lat_en    <= sprite_en;
                        r_lat_color <= sprite_color;
                        r_phase     <= ERASE;
                        r_idx       <= '0;
                        r_erased    <= 1'b0;
                        r_final     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (r_final) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        if (w_go) begin
                            r_state <= RECT;
                            if (r_phase == ERASE) r_erased <= 1'b1;
                        end
                        if (r_idx == c_idx_last) begin
                            r_idx <= '0;
                            if (r_phase == ERASE) begin
                                r_phase <= DRAW;
                            end else if (w_go) begin
                                r_final <= 1'b1;
                            end else begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_idx <= r_idx + c_iw'(1);
                        end
                    end
                end
                RECT: begin
                    if (w_last) r_state <= SCAN;
                end
                DONE: begin
                    r_prev_x  <= r_lat_x;
                    r_prev_y  <= r_lat_y;
                    r_prev_en <= r_lat_en;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;

    rect_scanner #(
        .SPRITE_WIDTH  (SPRITE_WIDTH),
        .SPRITE_HEIGHT (SPRITE_HEIGHT),
        .SCREEN_WIDTH  (SCREEN_WIDTH),
        .SCREEN_HEIGHT (SCREEN_HEIGHT),
        .X_W           (X_W),
        .Y_W           (Y_W),
        .COLOR_W       (COLOR_W)
    ) u_rect_scanner (
        .clock     (clock),
        .reset_n   (reset_n),
        .go        (w_go),
        .center_x  (w_cx),
        .center_y  (w_cy),
        .color     (w_color),
        .pix_ready (pix_ready),
        .pix_valid (pix_valid),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_color (out_color),
        .last      (w_last)
    );

endmodule
`default_nettype wire

// File: tb/tb_sprite_drawer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_drawer
//  Brief    : Randomised frame-level bench for sprite_drawer against a
//             rule-based pixel-list model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_drawer;

    localparam int NS  = 4;
    localparam int X_W = 10;
    localparam int Y_W = 9;
    localparam int C_W = 4;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              start;
    logic [NS*X_W-1:0] sprite_x;
    logic [NS*Y_W-1:0] sprite_y;
    logic [NS-1:0]     sprite_en;
    logic [NS*C_W-1:0] sprite_color;
    logic              pix_valid;
    logic              pix_ready;
    logic [X_W-1:0]    out_x;
    logic [Y_W-1:0]    out_y;
    logic [C_W-1:0]    out_color;
    logic              busy;
    logic              done;

    always #5 clock = ~clock;

    sprite_drawer #(
        .NUM_SPRITES(NS), .SPRITE_WIDTH(32), .SPRITE_HEIGHT(32),
        .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480),
        .X_W(X_W), .Y_W(Y_W), .COLOR_W(C_W)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_en(sprite_en),
        .sprite_color(sprite_color), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .out_x(out_x), .out_y(out_y), .out_color(out_color),
        .busy(busy), .done(done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int in_x[NS], in_y[NS], in_c[NS];
    bit in_en[NS];
    int pv_x[NS], pv_y[NS];
    bit pv_en[NS];

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          busy_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack_pix(input int x, input int y, input int c);
        logic [31:0] r;
        r = {9'd0, X_W'(x), Y_W'(y), C_W'(c)};
        return r;
    endfunction

    task automatic push_rect(input int cx, input int cy, input int c);
        for (int y = cy - 16; y < cy + 16; y++)
            for (int x = cx - 16; x < cx + 16; x++)
                if (x >= 0 && x < 640 && y >= 0 && y < 480)
                    exp_q.push_back(pack_pix(x, y, c));
    endtask

    // Expected pixel list from the frame rules: erase moved, then redraw.
    task automatic build_expected();
        bit moved[NS];
        bit any_erase = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NS; i++)
            moved[i] = (pv_en[i] != in_en[i]) ||
                       (in_en[i] && pv_en[i] && (pv_x[i] != in_x[i] || pv_y[i] != in_y[i]));
        for (int i = 0; i < NS; i++)
            if (moved[i] && pv_en[i]) begin
                push_rect(pv_x[i], pv_y[i], 0);
                any_erase = 1'b1;
            end
        for (int i = 0; i < NS; i++)
            if (in_en[i] && (any_erase || moved[i]))
                push_rect(in_x[i], in_y[i], in_c[i]);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NS; i++) begin
            sprite_x[i*X_W +: X_W]     = X_W'(in_x[i]);
            sprite_y[i*Y_W +: Y_W]     = Y_W'(in_y[i]);
            sprite_en[i]               = in_en[i];
            sprite_color[i*C_W +: C_W] = C_W'(in_c[i]);
        end
    endtask

    task automatic run_frame(input string name, input int stall_pct);
        int          done_cnt  = 0;
        int          hold_errs = 0;
        bit          holding   = 1'b0;
        logic [31:0] hold_val  = '0;
        int          bad       = -1;
        int          n;
        build_expected();
        got_q.delete();
        busy_cyc = 0;
        drive_inputs();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        // Inputs scrambled mid-frame must not affect the latched frame.
        sprite_x = NS*X_W'($urandom);
        sprite_y = NS*Y_W'($urandom);
        sprite_en = NS'($urandom);
        for (int cyc = 0; cyc < 20000 && done_cnt == 0; cyc++) begin
            start     = (cyc == 2);
            pix_ready = ($urandom_range(99) >= stall_pct);
            if (holding) begin
                if (!pix_valid || pack_pix(out_x, out_y, out_color) != hold_val)
                    hold_errs++;
                holding = 1'b0;
            end
            if (busy) busy_cyc++;
            if (done) done_cnt++;
            if (pix_valid && pix_ready) begin
                got_q.push_back(pack_pix(out_x, out_y, out_color));
            end else if (pix_valid) begin
                holding  = 1'b1;
                hold_val = pack_pix(out_x, out_y, out_color);
            end
            @(negedge clock);
        end
        start     = 1'b0;
        pix_ready = 1'b1;
        check({name, ":done_seen"}, done_cnt, 1);
        check({name, ":done_pulse_low"}, done, 1'b0);
        check({name, ":busy_low_after"}, busy, 1'b0);
        check({name, ":stall_hold_errs"}, hold_errs, 0);
        check({name, ":pix_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n && bad < 0; i++)
            if (got_q[i] !== exp_q[i]) bad = i;
        if (bad >= 0)
            check($sformatf("%s:pixel[%0d]", name, bad), got_q[bad], exp_q[bad]);
        else if (n > 0)
            check({name, ":last_pixel"}, got_q[n-1], exp_q[n-1]);
        for (int i = 0; i < NS; i++) begin
            pv_x[i]  = in_x[i];
            pv_y[i]  = in_y[i];
            pv_en[i] = in_en[i];
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ":pix_valid"}, pix_valid, 1'b0);
        check({name, ":out_x"}, out_x, '0);
        check({name, ":out_y"}, out_y, '0);
        check({name, ":out_color"}, out_color, '0);
        check({name, ":busy"}, busy, 1'b0);
        check({name, ":done"}, done, 1'b0);
    endtask

    initial begin
        int waited;
        reset_n = 1'b0;
        start = 1'b0;
        pix_ready = 1'b1;
        sprite_x = '0; sprite_y = '0; sprite_en = '0; sprite_color = '0;
        for (int i = 0; i < NS; i++) begin
            pv_x[i] = 0; pv_y[i] = 0; pv_en[i] = 1'b0;
            in_x[i] = $urandom_range(1023); in_y[i] = $urandom_range(511);
            in_c[i] = $urandom_range(15);   in_en[i] = 1'b0;
        end
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clock);

        in_x[0] = 320; in_y[0] = 454; in_c[0] = 1; in_en[0] = 1'b1;
        run_frame("first_draw", 0);
        check("first_draw:busy_cycles", busy_cyc, 1033);

        in_x[0] = 100; in_y[0] = 100;
        run_frame("move", 0);

        run_frame("no_change", 0);
        check("no_change:busy_cycles", busy_cyc, 9);

        in_x[1] = 5; in_y[1] = 470; in_c[1] = 2; in_en[1] = 1'b1;
        run_frame("clip", 0);
        check("clip:count", got_q.size(), 546);

        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NS; i++)
                if ($urandom_range(1)) begin
                    in_x[i]  = $urandom_range(1023);
                    in_y[i]  = $urandom_range(511);
                    in_c[i]  = $urandom_range(15);
                    in_en[i] = $urandom_range(3) != 0;
                end
            run_frame($sformatf("rand%0d", f), 30);
        end

        in_x[0] = 320; in_y[0] = 240; in_en[0] = 1'b1;
        drive_inputs();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        waited = 0;
        while (!pix_valid && waited < 5000) begin
            @(negedge clock);
            waited++;
        end
        check("midreset:pixel_seen", pix_valid, 1'b1);
        repeat (7) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < NS; i++) pv_en[i] = 1'b0;
        @(negedge clock);
        run_frame("after_reset", 20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
